// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding and frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; pop data is valid whenever the FIFO is non-empty.
// Writes while full and reads while empty are ignored, so callers may strobe blindly.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART 8N1 transmitter: byte strobes queue in a FIFO and are serialised LSB first, CLK_DIV clocks per bit.
// Strobe to start bit is 2 clocks; a strobe while the FIFO is full is dropped and sets the sticky overflow flag.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        tx_en,
    input  logic [7:0]                  tx_data,
    input  logic                        ovf_clr,
    output logic                        tx_ready,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        txd
);

    localparam int BW = $clog2(CLK_DIV);
    localparam int IW = $clog2(UART_DATA_BITS);

    tx_state_t                 state;
    tx_state_t                 state_nxt;
    logic [BW-1:0]             baud_cnt;
    logic                      baud_last;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [7:0]                fifo_dat;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .push     (tx_en),
        .push_dat (tx_data),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign baud_last = (baud_cnt == BW'(CLK_DIV - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = START;
            START:   if (baud_last) state_nxt = DATA;
            DATA:    if (baud_last && bit_idx == IW'(UART_DATA_BITS - 1)) state_nxt = STOP;
            STOP:    if (baud_last) state_nxt = fifo_empty ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    // Reloading straight from STOP keeps back-to-back frames gapless.
    always_comb begin
        txd = 1'b1;
        pop = 1'b0;
        case (state)
            IDLE:    pop = ~fifo_empty;
            START:   txd = 1'b0;
            DATA:    txd = shift[0];
            STOP:    pop = baud_last & ~fifo_empty;
            default: txd = 1'b1;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            if (state == IDLE || baud_last) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (pop) begin
                shift <= fifo_dat;
            end else if (state == DATA && baud_last) begin
                shift <= {1'b0, shift[UART_DATA_BITS-1:1]};
            end

            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA && baud_last) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // A dropped write in the same cycle as a clear leaves the flag set.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            overflow <= 1'b0;
        end else if (tx_en && fifo_full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    assign tx_ready = ~fifo_full;
    assign tx_busy  = (state != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLK_DIV=4, FIFO_DEPTH=4 and a line decoder on txd.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int CD = 4;

    logic       HCLK;
    logic       HRESETn;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       ovf_clr;
    logic       tx_ready;
    logic       tx_busy;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       txd;

    uart_tx_ctrl #(
        .CLK_DIV    (CD),
        .FIFO_DEPTH (4)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .ovf_clr    (ovf_clr),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .txd        (txd)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (tx_busy && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(tx_busy), 32'd0);
    endtask

    // Line decoder: samples the middle of every bit of each frame.
    logic [7:0] rx_q[$];
    logic       stop_q[$];
    int         start_q[$];
    int         max_cnt = 0;
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh  = '0;

    always @(posedge HCLK) begin
        #1;
        if (!HRESETn) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (txd == 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
        end
        if (mon_act && (mon_cnt % CD) == CD / 2) begin
            if (mon_cnt / CD >= 1 && mon_cnt / CD <= 8) mon_sh[mon_cnt / CD - 1] = txd;
            if (mon_cnt / CD == UART_FRAME_BITS - 1) begin
                rx_q.push_back(mon_sh);
                stop_q.push_back(txd);
            end
        end
        if (mon_act && mon_cnt == UART_FRAME_BITS * CD - 1) mon_act = 1'b0;
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end

    task automatic clear_mon();
        rx_q.delete();
        stop_q.delete();
        start_q.delete();
        max_cnt = 0;
    endtask

    typedef struct {
        logic       en;
        logic [7:0] dat;
        logic       clr;
        logic       exp_txd;
        logic       exp_rdy;
        logic       exp_busy;
        logic [2:0] exp_cnt;
        logic       exp_ovf;
    } vec_t;

    vec_t       vt[10];
    logic       a5_bits[10];
    logic [7:0] exp_seq[7];
    logic [3:0] samp;
    int         n0;
    int         bad;

    initial begin
        // en, dat, clr | txd, ready, busy, count, overflow (sampled after the edge)
        vt[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
        vt[1] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0};
        vt[2] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0};
        vt[3] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0};
        vt[4] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0};
        vt[5] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1};
        vt[6] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1};
        vt[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0};
        vt[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0};
        vt[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0};
        a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08};

        HRESETn = 1'b0;
        tx_en   = 1'b0;
        tx_data = 8'h00;
        ovf_clr = 1'b0;

        // Reset values while reset is held
        #12;
        chk("rst_txd",   32'(txd),        32'd1);
        chk("rst_ready", 32'(tx_ready),   32'd1);
        chk("rst_busy",  32'(tx_busy),    32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf",   32'(overflow),   32'd0);
        step();
        HRESETn = 1'b1;
        step();
        step();

        // Single byte 0xA5
        tx_en   = 1'b1;
        tx_data = 8'hA5;
        step();
        tx_en = 1'b0;
        chk("a5_txd_after_strobe", 32'(txd),        32'd1);
        chk("a5_count",            32'(fifo_count), 32'd1);
        chk("a5_busy",             32'(tx_busy),    32'd1);
        for (int b = 0; b < 10; b++) begin
            for (int s = 0; s < CD; s++) begin
                step();
                samp[s] = txd;
            end
            chk($sformatf("a5_bit%0d", b), 32'(samp), a5_bits[b] ? 32'hF : 32'h0);
        end
        chk("a5_busy_last_stop", 32'(tx_busy), 32'd1);
        step();
        chk("a5_busy_done", 32'(tx_busy), 32'd0);
        chk("a5_txd_idle",  32'(txd),     32'd1);
        chk("a5_rx_byte",   rx_q.size() > 0 ? 32'(rx_q[0]) : 32'hFFFF, 32'hA5);
        clear_mon();

        // Burst of strobes, overflow set/clear interplay
        for (int i = 0; i < 10; i++) begin
            tx_en   = vt[i].en;
            tx_data = vt[i].dat;
            ovf_clr = vt[i].clr;
            step();
            if (i == 0) n0 = cyc;
            chk($sformatf("vec%0d_txd", i),   32'(txd),        32'(vt[i].exp_txd));
            chk($sformatf("vec%0d_ready", i), 32'(tx_ready),   32'(vt[i].exp_rdy));
            chk($sformatf("vec%0d_busy", i),  32'(tx_busy),    32'(vt[i].exp_busy));
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vt[i].exp_cnt));
            chk($sformatf("vec%0d_ovf", i),   32'(overflow),   32'(vt[i].exp_ovf));
        end
        tx_en   = 1'b0;
        ovf_clr = 1'b0;

        bad = 0;
        while (cyc < n0 + 40) begin
            step();
            if (tx_ready !== 1'b0) bad++;
        end
        chk("ready_low_until_pop", 32'(bad), 32'd0);
        step();
        chk("ready_after_pop", 32'(tx_ready),   32'd1);
        chk("count_after_pop", 32'(fifo_count), 32'd3);

        tx_en   = 1'b1;
        tx_data = 8'h06;
        step();
        tx_en = 1'b0;
        chk("refill_count", 32'(fifo_count), 32'd4);
        chk("refill_ready", 32'(tx_ready),   32'd0);

        // Push while full coinciding with the STOP-end pop is still dropped
        while (cyc < n0 + 80) step();
        tx_en   = 1'b1;
        tx_data = 8'h07;
        step();
        tx_en = 1'b0;
        chk("full_push_at_pop_ovf",   32'(overflow),   32'd1);
        chk("full_push_at_pop_count", 32'(fifo_count), 32'd3);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Push and pop together at count 2
        while (cyc < n0 + 160) step();
        tx_en   = 1'b1;
        tx_data = 8'h08;
        step();
        tx_en = 1'b0;
        chk("push_pop_count", 32'(fifo_count), 32'd2);

        wait_idle(400, "burst_drain");
        chk("burst_drain_cycle", 32'(cyc - n0), 32'd281);
        chk("burst_rx_count", 32'(rx_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < rx_q.size(); i++) begin
            chk($sformatf("burst_rx%0d", i), 32'(rx_q[i]), 32'(exp_seq[i]));
            chk($sformatf("burst_stop%0d", i), 32'(stop_q[i]), 32'd1);
            chk($sformatf("burst_start%0d", i), 32'(start_q[i] - n0), 32'(1 + 40 * i));
        end
        chk("burst_max_count", 32'(max_cnt), 32'd4);

        // Pointer wrap: nine bytes with gaps
        HRESETn = 1'b0;
        step();
        HRESETn = 1'b1;
        step();
        clear_mon();
        for (int k = 0; k < 9; k++) begin
            tx_en   = 1'b1;
            tx_data = 8'h10 + 8'(k);
            step();
            tx_en = 1'b0;
            repeat (24) step();
        end
        wait_idle(600, "wrap_drain");
        chk("wrap_rx_count", 32'(rx_q.size()), 32'd9);
        for (int k = 0; k < 9 && k < rx_q.size(); k++) begin
            chk($sformatf("wrap_rx%0d", k), 32'(rx_q[k]), 32'h10 + 32'(k));
        end
        chk("wrap_ovf",          32'(overflow),    32'd0);
        chk("wrap_max_count_le4", 32'(max_cnt > 4), 32'd0);

        // Reset mid-frame aborts at once
        tx_en   = 1'b1;
        tx_data = 8'h00;
        step();
        tx_en = 1'b0;
        repeat (9) step();
        chk("abort_pre_txd", 32'(txd), 32'd0);
        #3;
        HRESETn = 1'b0;
        #1;
        chk("abort_txd",   32'(txd),        32'd1);
        chk("abort_busy",  32'(tx_busy),    32'd0);
        chk("abort_count", 32'(fifo_count), 32'd0);
        chk("abort_ready", 32'(tx_ready),   32'd1);
        step();
        step();
        HRESETn = 1'b1;
        step();
        step();
        chk("abort_stays_idle", 32'(txd), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side controller for the AHB-lite UART register block. Accepts the one-cycle byte-write strobe (tx_en + 8-bit data) produced by a bus write to UART offset 0x0. Buffers bytes in a small FIFO and sequences a baud-timed 8N1 serializer onto the TX pin. Returns a ready flag that the register block exposes as its status bit at offset 0x4.

Parameters:
CLK_DIV, 434, HCLK cycles per serial bit (434 = 50 MHz / 115200); legal range 2..65535.
FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16.

Ports:
HCLK  input  1  system clock; all state changes on rising edge.
HRESETn  input  1  asynchronous, active-low reset.
tx_en  input  1  one-cycle byte-write strobe from the bus register block.
tx_data  input  8  byte to send; sampled only when tx_en=1.
ovf_clr  input  1  clears the overflow flag.
tx_ready  output  1  1 = FIFO not full; feeds the register block's status input.
tx_busy  output  1  1 = serializer mid-frame or FIFO non-empty.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the frame being shifted.
overflow  output  1  sticky flag: a write arrived while the FIFO was full.
txd  output  1  serial line; idle high.

Behaviour:
- Reset (async, HRESETn=0): txd=1, tx_ready=1, tx_busy=0, fifo_count=0, overflow=0. FSM goes to IDLE. FIFO pointers, baud counter and bit counter clear. A reset mid-frame aborts the frame immediately and drives txd high.
- Push: tx_en=1 and full=0 writes tx_data at the rising edge. full is the registered condition count==FIFO_DEPTH.
- Push while full: the byte is dropped and overflow is set. A pop in the same cycle does not rescue the byte.
- Overflow flag: ovf_clr=1 clears it. If ovf_clr and a dropped write occur in the same cycle, the set wins.
- Pop: happens only when the FSM loads a byte (see IDLE and STOP). Push and pop in the same cycle: count is unchanged, data ordering is preserved, and the read and write pointers each advance by 1. Pointers wrap modulo FIFO_DEPTH.
- tx_ready = ~full, registered (derived from count). tx_busy = (state!=IDLE) | (count!=0).
- FSM states:
  - IDLE: txd=1. If count!=0, pop into the shift register, clear the baud counter, and go to START.
  - START: txd=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0], LSB first, for CLK_DIV cycles per bit. The register shifts right after each bit. After bit 7 completes, go to STOP.
  - STOP: txd=1 for CLK_DIV cycles. On the last cycle, if count!=0, pop and go to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLK_DIV-1 and wraps. A bit ends on the cycle where counter==CLK_DIV-1. A frame lasts exactly 10*CLK_DIV cycles.
- Latency: with the FSM in IDLE and the FIFO empty, tx_en is sampled at edge N. The FIFO is non-empty after edge N, the pop happens at edge N+1, and txd falls after edge N+1. That is 2 clocks from strobe to start bit.
- fifo_count decrements at the pop edge, so the byte in flight is not counted.
- Total capacity is FIFO_DEPTH queued bytes plus 1 in the shifter.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding typedef (IDLE=0, START=1, DATA=2, STOP=3);
  - constant UART_DATA_BITS=8;
  - constant UART_FRAME_BITS=10.
- One sub-module is natural: uart_sync_fifo (parameters WIDTH, DEPTH). It is single-clock, with push/pop/full/empty/count ports and a write-when-full block.
- The FSM, baud counter and shifter stay in uart_tx_ctrl.

Test Plan:
- Reset with CLK_DIV=4 → txd=1, tx_ready=1, tx_busy=0, fifo_count=0, overflow=0. Asserting HRESETn low mid-frame returns txd to 1 asynchronously.
- Single byte 0xA5, strobe at edge N → txd falls after edge N+1. txd then carries 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). tx_busy deasserts the cycle after the stop bit ends.
- 5 back-to-back strobes 0x01..0x05 with FIFO_DEPTH=4 → first byte popped immediately, all 5 accepted, no overflow. Frames are contiguous with no idle gap, 200 cycles total. Output order is 0x01..0x05.
- 6 strobes on consecutive cycles → 6th write dropped, overflow=1, tx_ready=0 until the next pop. ovf_clr then clears overflow. A simultaneous ovf_clr and dropped write leaves overflow=1.
- Full FIFO, push coinciding with the STOP-end pop → push dropped and overflow set. With count=2 and push plus pop in the same cycle → count stays 2 and order is preserved.
- Pointer wrap: send 9 bytes with gaps → every byte is transmitted in order across the pointer wrap, and fifo_count never exceeds 4.
